// File: rtl/gt_wizard_pkg.sv
// gt_wizard shared types and constants.
// Reset FSM states, loopback word bundle, K28.5 helper.
package gt_wizard_pkg;

  localparam int CNT_W = 16;
  localparam logic [7:0] K28_5 = 8'hBC;

  localparam int DEF_PLL_LOCK_CYCLES  = 64;
  localparam int DEF_GTRESET_CYCLES   = 16;
  localparam int DEF_RESETDONE_CYCLES = 8;
  localparam int DEF_VALID_CYCLES     = 4;
  localparam int DEF_DATA_ERR_TIMEOUT = 32;
  localparam int DEF_LOOPBACK_LATENCY = 4;

  typedef enum logic [2:0] {
    ST_PLL_WAIT,
    ST_GT_RESET,
    ST_WAIT_USERRDY,
    ST_WAIT_DONE,
    ST_WAIT_VALID,
    ST_DONE
  } rst_state_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  k;
  } lb_word_t;

  function automatic logic is_comma(
    input logic [7:0] b,
    input logic       k
  );
    return k && (b == K28_5);
  endfunction

endpackage

// File: rtl/gt_wizard_if.sv
// gt_wizard user datapath bundle.
// master = user logic, slave = wizard.
interface gt_wizard_if;
  logic [15:0] gt0_txdata_in;
  logic [1:0]  gt0_txcharisk_in;
  logic [15:0] gt0_rxdata_out;
  logic [1:0]  gt0_rxcharisk_out;
  logic        gt0_rxcommadet_out;
  logic        gt0_rxbyteisaligned_out;

  modport master (
    output gt0_txdata_in, gt0_txcharisk_in,
    input  gt0_rxdata_out, gt0_rxcharisk_out,
    input  gt0_rxcommadet_out,
    input  gt0_rxbyteisaligned_out
  );

  modport slave (
    input  gt0_txdata_in, gt0_txcharisk_in,
    output gt0_rxdata_out, gt0_rxcharisk_out,
    output gt0_rxcommadet_out,
    output gt0_rxbyteisaligned_out
  );
endinterface

// File: rtl/gt_wizard_rst_fsm.sv
// Per-direction GT reset sequencer.
// HAS_DATA_VALID adds valid qualification and data-error re-reset.
module gt_wizard_rst_fsm
  import gt_wizard_pkg::*;
#(
  parameter int GTRESET_CYCLES   = DEF_GTRESET_CYCLES,
  parameter int RESETDONE_CYCLES = DEF_RESETDONE_CYCLES,
  parameter int VALID_CYCLES     = DEF_VALID_CYCLES,
  parameter int DATA_ERR_TIMEOUT = DEF_DATA_ERR_TIMEOUT,
  parameter bit HAS_DATA_VALID   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pll_lock,
  input  logic i_soft_reset,
  input  logic i_userrdy,
  input  logic i_data_valid,
  input  logic i_dont_reset,
  output logic o_resetdone,
  output logic o_fsm_done
);

  localparam logic [CNT_W-1:0] GR_L = CNT_W'(GTRESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_L = CNT_W'(RESETDONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] VC_L = CNT_W'(VALID_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_L = CNT_W'(DATA_ERR_TIMEOUT - 1);

  rst_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_vcnt, w_vcnt_nxt;
  logic [CNT_W-1:0] r_ecnt, w_ecnt_nxt;
  logic             r_resetdone, w_resetdone_nxt;
  logic             r_done, w_done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_PLL_WAIT;
      r_cnt       <= '0;
      r_vcnt      <= '0;
      r_ecnt      <= '0;
      r_resetdone <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_vcnt      <= w_vcnt_nxt;
      r_ecnt      <= w_ecnt_nxt;
      r_resetdone <= w_resetdone_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_vcnt_nxt      = r_vcnt;
    w_ecnt_nxt      = r_ecnt;
    w_resetdone_nxt = r_resetdone;
    w_done_nxt      = r_done;
    // Soft reset outranks every other transition, including data error.
    if (i_soft_reset && r_state != ST_PLL_WAIT) begin
      w_state_nxt     = ST_GT_RESET;
      w_cnt_nxt       = '0;
      w_vcnt_nxt      = '0;
      w_ecnt_nxt      = '0;
      w_resetdone_nxt = 1'b0;
      w_done_nxt      = 1'b0;
    end else begin
      unique case (r_state)
        ST_PLL_WAIT: begin
          if (i_pll_lock) begin
            w_state_nxt = ST_GT_RESET;
            w_cnt_nxt   = '0;
          end
        end
        ST_GT_RESET: begin
          if (r_cnt == GR_L) begin
            w_state_nxt = i_userrdy ? ST_WAIT_DONE
                                    : ST_WAIT_USERRDY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_WAIT_USERRDY: begin
          if (i_userrdy) begin
            w_state_nxt = ST_WAIT_DONE;
            w_cnt_nxt   = '0;
          end
        end
        ST_WAIT_DONE: begin
          // Leave one cycle after resetdone so done follows it.
          if (r_resetdone) begin
            if (HAS_DATA_VALID) begin
              w_state_nxt = ST_WAIT_VALID;
              w_vcnt_nxt  = CNT_W'(i_data_valid);
              w_ecnt_nxt  = CNT_W'(!i_data_valid);
            end else begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end
          end else if (r_cnt == RD_L) begin
            w_resetdone_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_WAIT_VALID, ST_DONE: begin
          if (!i_data_valid) begin
            if (r_ecnt == TO_L && !i_dont_reset) begin
              w_state_nxt     = ST_GT_RESET;
              w_cnt_nxt       = '0;
              w_vcnt_nxt      = '0;
              w_ecnt_nxt      = '0;
              w_resetdone_nxt = 1'b0;
              w_done_nxt      = 1'b0;
            end else begin
              w_state_nxt = ST_WAIT_VALID;
              w_vcnt_nxt  = '0;
              w_done_nxt  = 1'b0;
              if (r_ecnt != TO_L)
                w_ecnt_nxt = r_ecnt + 1'b1;
            end
          end else begin
            w_ecnt_nxt = '0;
            if (r_state == ST_WAIT_VALID) begin
              if (r_vcnt == VC_L) begin
                w_state_nxt = ST_DONE;
                w_done_nxt  = 1'b1;
              end else begin
                w_vcnt_nxt = r_vcnt + 1'b1;
              end
            end
          end
        end
        default: w_state_nxt = ST_PLL_WAIT;
      endcase
    end
  end

  assign o_resetdone = r_resetdone;
  assign o_fsm_done  = r_done;

endmodule

// File: rtl/gt_wizard.sv
// Single-lane GTP wizard model: PLL, TX/RX reset sequencing,
// near-end loopback datapath and K28.5 byte alignment.
module gt_wizard
  import gt_wizard_pkg::*;
#(
  parameter int PLL_LOCK_CYCLES  = DEF_PLL_LOCK_CYCLES,
  parameter int GTRESET_CYCLES   = DEF_GTRESET_CYCLES,
  parameter int RESETDONE_CYCLES = DEF_RESETDONE_CYCLES,
  parameter int VALID_CYCLES     = DEF_VALID_CYCLES,
  parameter int DATA_ERR_TIMEOUT = DEF_DATA_ERR_TIMEOUT,
  parameter int LOOPBACK_LATENCY = DEF_LOOPBACK_LATENCY
) (
  input  logic sysclk_in,
  input  logic rst_n_in,
  input  logic soft_reset_tx_in,
  input  logic soft_reset_rx_in,
  input  logic dont_reset_on_data_error_in,
  input  logic gt0_data_valid_in,
  input  logic gt0_txuserrdy_in,
  input  logic gt0_rxuserrdy_in,
  input  logic gt0_rxmcommaalignen_in,
  input  logic gt0_rxpcommaalignen_in,
  input  logic gt0_gtprxp_in,
  input  logic gt0_gtprxn_in,
  gt_wizard_if.slave gt0_dp,
  output logic gt0_txusrclk2_out,
  output logic gt0_rxusrclk2_out,
  output logic gt0_pll0lock_out,
  output logic gt0_txresetdone_out,
  output logic gt0_rxresetdone_out,
  output logic gt0_tx_fsm_reset_done_out,
  output logic gt0_rx_fsm_reset_done_out,
  output logic gt0_gtptxp_out,
  output logic gt0_gtptxn_out
);

  localparam logic [CNT_W-1:0] LOCK_L = CNT_W'(PLL_LOCK_CYCLES - 1);

  logic [CNT_W-1:0] r_pll_cnt;
  logic             r_pll_lock;
  logic             w_pll_lock_d;
  logic             w_txrd, w_rxrd;
  logic             w_unused;

  lb_word_t    r_pipe [LOOPBACK_LATENCY];
  lb_word_t    w_tx_word, w_cur, w_al;
  logic [7:0]  r_prev_hi;
  logic        r_prev_k1;
  logic        r_off;
  logic        w_com0, w_com1, w_flip;
  logic [15:0] r_rxdata;
  logic [1:0]  r_rxk;
  logic        r_commadet, r_aligned;

  assign w_unused = ^{gt0_gtprxp_in, gt0_gtprxn_in};

  // FSMs see lock on the same edge it registers.
  assign w_pll_lock_d = r_pll_lock | (r_pll_cnt == LOCK_L);

  always_ff @(posedge sysclk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pll_cnt  <= '0;
      r_pll_lock <= 1'b0;
    end else if (!r_pll_lock) begin
      r_pll_lock <= w_pll_lock_d;
      r_pll_cnt  <= r_pll_cnt + 1'b1;
    end
  end

  gt_wizard_rst_fsm #(
    .GTRESET_CYCLES  (GTRESET_CYCLES),
    .RESETDONE_CYCLES(RESETDONE_CYCLES),
    .VALID_CYCLES    (VALID_CYCLES),
    .DATA_ERR_TIMEOUT(DATA_ERR_TIMEOUT),
    .HAS_DATA_VALID  (1'b0)
  ) u_tx_fsm (
    .clk         (sysclk_in),
    .rst_n       (rst_n_in),
    .i_pll_lock  (w_pll_lock_d),
    .i_soft_reset(soft_reset_tx_in),
    .i_userrdy   (gt0_txuserrdy_in),
    .i_data_valid(1'b1),
    .i_dont_reset(1'b1),
    .o_resetdone (w_txrd),
    .o_fsm_done  (gt0_tx_fsm_reset_done_out)
  );

  gt_wizard_rst_fsm #(
    .GTRESET_CYCLES  (GTRESET_CYCLES),
    .RESETDONE_CYCLES(RESETDONE_CYCLES),
    .VALID_CYCLES    (VALID_CYCLES),
    .DATA_ERR_TIMEOUT(DATA_ERR_TIMEOUT),
    .HAS_DATA_VALID  (1'b1)
  ) u_rx_fsm (
    .clk         (sysclk_in),
    .rst_n       (rst_n_in),
    .i_pll_lock  (w_pll_lock_d),
    .i_soft_reset(soft_reset_rx_in),
    .i_userrdy   (gt0_rxuserrdy_in),
    .i_data_valid(gt0_data_valid_in),
    .i_dont_reset(dont_reset_on_data_error_in),
    .o_resetdone (w_rxrd),
    .o_fsm_done  (gt0_rx_fsm_reset_done_out)
  );

  always_comb begin
    w_tx_word = '0;
    if (w_txrd) begin
      w_tx_word.data = gt0_dp.gt0_txdata_in;
      w_tx_word.k    = gt0_dp.gt0_txcharisk_in;
    end
  end

  assign w_cur = r_pipe[LOOPBACK_LATENCY-1];

  always_comb begin
    w_al = w_cur;
    if (r_off) begin
      w_al.data = {w_cur.data[7:0], r_prev_hi};
      w_al.k    = {w_cur.k[0], r_prev_k1};
    end
  end

  assign w_com0 = is_comma(w_al.data[7:0], w_al.k[0]);
  assign w_com1 = is_comma(w_al.data[15:8], w_al.k[1]);
  assign w_flip = (gt0_rxmcommaalignen_in | gt0_rxpcommaalignen_in)
                & is_comma(w_cur.data[15:8], w_cur.k[1]);

  always_ff @(posedge sysclk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < LOOPBACK_LATENCY; i++)
        r_pipe[i] <= '0;
      r_prev_hi  <= '0;
      r_prev_k1  <= 1'b0;
      r_off      <= 1'b0;
      r_rxdata   <= '0;
      r_rxk      <= '0;
      r_commadet <= 1'b0;
      r_aligned  <= 1'b0;
    end else begin
      r_pipe[0] <= w_tx_word;
      for (int i = 1; i < LOOPBACK_LATENCY; i++)
        r_pipe[i] <= r_pipe[i-1];
      r_prev_hi  <= w_cur.data[15:8];
      r_prev_k1  <= w_cur.k[1];
      r_off      <= r_off ^ w_flip;
      r_rxdata   <= w_rxrd ? w_al.data : '0;
      r_rxk      <= w_rxrd ? w_al.k : '0;
      r_commadet <= w_rxrd & (w_com0 | w_com1);
      if (w_flip || !w_rxrd)
        r_aligned <= 1'b0;
      else if (w_com0)
        r_aligned <= 1'b1;
    end
  end

  assign gt0_dp.gt0_rxdata_out          = r_rxdata;
  assign gt0_dp.gt0_rxcharisk_out       = r_rxk;
  assign gt0_dp.gt0_rxcommadet_out      = r_commadet;
  assign gt0_dp.gt0_rxbyteisaligned_out = r_aligned;

  assign gt0_txusrclk2_out   = sysclk_in;
  assign gt0_rxusrclk2_out   = sysclk_in;
  assign gt0_pll0lock_out    = r_pll_lock;
  assign gt0_txresetdone_out = w_txrd;
  assign gt0_rxresetdone_out = w_rxrd;
  assign gt0_gtptxp_out      = 1'b0;
  assign gt0_gtptxn_out      = 1'b1;

endmodule

// File: tb/tb_gt_wizard.sv
// Directed bench for gt_wizard: reset sequencing, soft reset,
// loopback, comma alignment, data-error re-reset, async reset.
module tb_gt_wizard;

  logic clk = 1'b0;
  logic rst_n;
  logic soft_tx, soft_rx, dont_rst;
  logic dv, force_low;
  logic txurdy, rxurdy;
  logic mcomma, pcomma;
  logic rxp, rxn;
  logic txclk, rxclk, lock;
  logic txrd, rxrd, txdone, rxdone;
  logic txp, txn;

  int checks = 0;
  int errors = 0;

  gt_wizard_if dp();

  assign dv = rxrd & ~force_low;

  gt_wizard dut (
    .sysclk_in                  (clk),
    .rst_n_in                   (rst_n),
    .soft_reset_tx_in           (soft_tx),
    .soft_reset_rx_in           (soft_rx),
    .dont_reset_on_data_error_in(dont_rst),
    .gt0_data_valid_in          (dv),
    .gt0_txuserrdy_in           (txurdy),
    .gt0_rxuserrdy_in           (rxurdy),
    .gt0_rxmcommaalignen_in     (mcomma),
    .gt0_rxpcommaalignen_in     (pcomma),
    .gt0_gtprxp_in              (rxp),
    .gt0_gtprxn_in              (rxn),
    .gt0_dp                     (dp),
    .gt0_txusrclk2_out          (txclk),
    .gt0_rxusrclk2_out          (rxclk),
    .gt0_pll0lock_out           (lock),
    .gt0_txresetdone_out        (txrd),
    .gt0_rxresetdone_out        (rxrd),
    .gt0_tx_fsm_reset_done_out  (txdone),
    .gt0_rx_fsm_reset_done_out  (rxdone),
    .gt0_gtptxp_out             (txp),
    .gt0_gtptxn_out             (txn)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] k);
    dp.gt0_txdata_in    = d;
    dp.gt0_txcharisk_in = k;
  endtask

  task automatic chk_rx(input string tag,
                        input logic [15:0] d, input logic [1:0] k,
                        input logic cd, input logic al);
    chk({tag, "_data"}, 32'(dp.gt0_rxdata_out), 32'(d));
    chk({tag, "_k"}, 32'(dp.gt0_rxcharisk_out), 32'(k));
    chk({tag, "_cdet"}, 32'(dp.gt0_rxcommadet_out), 32'(cd));
    chk({tag, "_algn"}, 32'(dp.gt0_rxbyteisaligned_out), 32'(al));
  endtask

  initial begin
    rst_n = 1'b0; soft_tx = 1'b0; soft_rx = 1'b0;
    dont_rst = 1'b0; force_low = 1'b0;
    txurdy = 1'b1; rxurdy = 1'b1;
    mcomma = 1'b1; pcomma = 1'b0;
    rxp = 1'b0; rxn = 1'b0;
    send(16'h0000, 2'b00);
    #2;
    chk("rst_lock", 32'(lock), 0);
    chk("rst_txrd", 32'(txrd), 0);
    chk("rst_rxrd", 32'(rxrd), 0);
    chk("rst_txdone", 32'(txdone), 0);
    chk("rst_rxdone", 32'(rxdone), 0);
    chk("rst_txp", 32'(txp), 0);
    chk("rst_txn", 32'(txn), 1);
    chk_rx("rst_rx", 16'h0, 2'b00, 1'b0, 1'b0);

    step(3);
    rst_n = 1'b1;
    step(63);
    chk("lock_63", 32'(lock), 0);
    step(1);
    chk("lock_64", 32'(lock), 1);
    step(23);
    chk("txrd_87", 32'(txrd), 0);
    chk("rxrd_87", 32'(rxrd), 0);
    step(1);
    chk("txrd_88", 32'(txrd), 1);
    chk("rxrd_88", 32'(rxrd), 1);
    chk("txdone_88", 32'(txdone), 0);
    step(1);
    chk("txdone_89", 32'(txdone), 1);
    chk("rxdone_89", 32'(rxdone), 0);
    step(2);
    chk("rxdone_91", 32'(rxdone), 0);
    step(1);
    chk("rxdone_92", 32'(rxdone), 1);

    soft_tx = 1'b1;
    step(1);
    soft_tx = 1'b0;
    chk("stx_txrd", 32'(txrd), 0);
    chk("stx_txdone", 32'(txdone), 0);
    chk("stx_rxrd", 32'(rxrd), 1);
    chk("stx_rxdone", 32'(rxdone), 1);
    step(23);
    chk("stx_txrd_23", 32'(txrd), 0);
    step(1);
    chk("stx_txrd_24", 32'(txrd), 1);
    step(1);
    chk("stx_txdone", 32'(txdone), 1);
    chk("stx_rxdone2", 32'(rxdone), 1);

    send(16'h50BC, 2'b01);
    step(4);
    chk("lb_lat4", 32'(dp.gt0_rxdata_out), 0);
    step(1);
    chk_rx("lb_lat5", 16'h50BC, 2'b01, 1'b1, 1'b1);

    send(16'hBC50, 2'b10);
    step(1);
    send(16'h1234, 2'b00);
    step(3);
    chk_rx("hi_pre", 16'h50BC, 2'b01, 1'b1, 1'b1);
    step(1);
    chk_rx("hi_flip", 16'hBC50, 2'b10, 1'b1, 1'b0);
    step(1);
    chk_rx("hi_lane0", 16'h34BC, 2'b01, 1'b1, 1'b1);
    step(1);
    chk_rx("hi_after", 16'h3412, 2'b00, 1'b0, 1'b1);

    mcomma = 1'b0;
    send(16'hBC50, 2'b10);
    step(1);
    send(16'h1234, 2'b00);
    step(4);
    chk_rx("dis_word", 16'h5012, 2'b00, 1'b0, 1'b1);
    step(1);
    chk_rx("dis_keep", 16'h34BC, 2'b01, 1'b1, 1'b1);

    force_low = 1'b1;
    step(1);
    chk("to_done_drop", 32'(rxdone), 0);
    chk("to_rxrd_1", 32'(rxrd), 1);
    step(30);
    chk("to_rxrd_31", 32'(rxrd), 1);
    step(1);
    chk("to_rxrd_32", 32'(rxrd), 0);
    force_low = 1'b0;
    step(2);
    chk_rx("to_rx_zero", 16'h0, 2'b00, 1'b0, 1'b0);
    chk("to_txdone", 32'(txdone), 1);
    step(21);
    chk("to_rxrd_55", 32'(rxrd), 0);
    step(1);
    chk("to_rxrd_56", 32'(rxrd), 1);
    step(3);
    chk("to_rxdone_59", 32'(rxdone), 0);
    step(1);
    chk("to_rxdone_60", 32'(rxdone), 1);

    dont_rst = 1'b1;
    force_low = 1'b1;
    step(1);
    chk("dr_done_drop", 32'(rxdone), 0);
    step(40);
    chk("dr_rxrd_held", 32'(rxrd), 1);
    force_low = 1'b0;
    step(3);
    chk("dr_rxdone_3", 32'(rxdone), 0);
    step(1);
    chk("dr_rxdone_4", 32'(rxdone), 1);
    dont_rst = 1'b0;
    chk("dr_rxdata", 32'(dp.gt0_rxdata_out), 32'h3412);

    soft_rx = 1'b1;
    step(1);
    soft_rx = 1'b0;
    chk("srx_rxrd", 32'(rxrd), 0);
    chk("srx_rxdone", 32'(rxdone), 0);
    chk("srx_txrd", 32'(txrd), 1);
    step(24);
    chk("srx_rxrd_24", 32'(rxrd), 1);

    step(3);
    rst_n = 1'b0;
    #1;
    chk("ar_lock", 32'(lock), 0);
    chk("ar_txrd", 32'(txrd), 0);
    chk("ar_rxrd", 32'(rxrd), 0);
    chk("ar_txdone", 32'(txdone), 0);
    chk("ar_rxdone", 32'(rxdone), 0);
    chk("ar_txn", 32'(txn), 1);
    chk("ar_txclk", 32'(txclk), 32'(clk));
    chk("ar_rxclk", 32'(rxclk), 32'(clk));
    chk_rx("ar_rx", 16'h0, 2'b00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
